// File: rtl/rename_reg_file_pkg.sv
// Shared widths, types and helpers for the rename register file.
package rename_reg_file_pkg;

  localparam int unsigned NUM_REGS     = 32;
  localparam int unsigned REG_WIDTH    = 5;
  localparam int unsigned VAL_WIDTH    = 32;
  localparam int unsigned ROB_ID_WIDTH = 4;
  localparam int unsigned ROB_SIZE     = 2 ** ROB_ID_WIDTH;
  localparam int unsigned LAB_WIDTH    = ROB_ID_WIDTH + 1;

  typedef logic [REG_WIDTH-1:0] reg_idx_t;
  typedef logic [VAL_WIDTH-1:0] val_t;
  typedef logic [LAB_WIDTH-1:0] lab_t;

  // Label value meaning "no in-flight writer"; real ROB tags are 1..ROB_SIZE.
  localparam lab_t LAB_NONE = LAB_WIDTH'(0);

  // Highest legal tag, kept next to the label width so the two cannot drift apart.
  localparam lab_t LAB_MAX = LAB_WIDTH'(ROB_SIZE);

  // True when the committing instruction is the newest writer of idx.
  function automatic logic commit_hits(input logic     commit_en,
                                       input reg_idx_t commit_rd,
                                       input lab_t     commit_lab,
                                       input reg_idx_t idx,
                                       input lab_t     lab_at_idx);
    return commit_en && (commit_rd == idx) && (lab_at_idx == commit_lab);
  endfunction

endpackage

// File: rtl/rename_reg_file_if.sv
// Decode/commit request signals and operand read responses of the rename register file.
interface rename_reg_file_if;
  import rename_reg_file_pkg::*;

  logic     dec_en;
  reg_idx_t dec_rd;
  lab_t     dec_tag;
  reg_idx_t dec_rs1;
  reg_idx_t dec_rs2;

  logic     commit_en;
  reg_idx_t commit_rd;
  val_t     commit_res;
  lab_t     commit_lab;

  lab_t     rf_label1;
  val_t     rf_val1;
  lab_t     rf_label2;
  val_t     rf_val2;

  // Issue/ROB side: drives requests, consumes operands.
  modport master (
    output dec_en, dec_rd, dec_tag, dec_rs1, dec_rs2,
    output commit_en, commit_rd, commit_res, commit_lab,
    input  rf_label1, rf_val1, rf_label2, rf_val2
  );

  // Register file side.
  modport slave (
    input  dec_en, dec_rd, dec_tag, dec_rs1, dec_rs2,
    input  commit_en, commit_rd, commit_res, commit_lab,
    output rf_label1, rf_val1, rf_label2, rf_val2
  );

endinterface

// File: rtl/rename_reg_file_rf_read_port.sv
// One combinational operand read port: x0, commit bypass, then stored label/value.
module rename_reg_file_rf_read_port
  import rename_reg_file_pkg::*;
(
  input  reg_idx_t rs,
  input  lab_t     lab_rs,
  input  val_t     val_rs,
  input  logic     commit_en,
  input  reg_idx_t commit_rd,
  input  lab_t     commit_lab,
  input  val_t     commit_res,
  output lab_t     label_c,
  output val_t     val_c
);

  // Bypass is needed because the ROB drops the entry's ready bit on commit.
  always_comb begin
    label_c = LAB_NONE;
    val_c   = '0;
    if (rs == '0) begin
      label_c = LAB_NONE;
      val_c   = '0;
    end else if (commit_hits(commit_en, commit_rd, commit_lab, rs, lab_rs)) begin
      label_c = LAB_NONE;
      val_c   = commit_res;
    end else begin
      label_c = lab_rs;
      val_c   = val_rs;
    end
  end

endmodule

// File: rtl/rename_reg_file.sv
// Architectural register file with per-register rename labels (newest ROB writer).
module rename_reg_file
  import rename_reg_file_pkg::*;
(
  input  logic                   clk,
  input  logic                   rst_in,
  input  logic                   rdy_in,
  input  logic                   flush_in,
  rename_reg_file_if.slave       bus
);

  val_t val_q [NUM_REGS];
  lab_t lab_q [NUM_REGS];

  lab_t lab_rs1;
  lab_t lab_rs2;
  val_t val_rs1;
  val_t val_rs2;
  lab_t lab_commit;

  // Raw array lookups feeding the read ports and the commit tag match.
  assign lab_rs1    = lab_q[bus.dec_rs1];
  assign val_rs1    = val_q[bus.dec_rs1];
  assign lab_rs2    = lab_q[bus.dec_rs2];
  assign val_rs2    = val_q[bus.dec_rs2];
  assign lab_commit = lab_q[bus.commit_rd];

  rename_reg_file_rf_read_port u_port1 (
    .rs         (bus.dec_rs1),
    .lab_rs     (lab_rs1),
    .val_rs     (val_rs1),
    .commit_en  (bus.commit_en),
    .commit_rd  (bus.commit_rd),
    .commit_lab (bus.commit_lab),
    .commit_res (bus.commit_res),
    .label_c    (bus.rf_label1),
    .val_c      (bus.rf_val1)
  );

  rename_reg_file_rf_read_port u_port2 (
    .rs         (bus.dec_rs2),
    .lab_rs     (lab_rs2),
    .val_rs     (val_rs2),
    .commit_en  (bus.commit_en),
    .commit_rd  (bus.commit_rd),
    .commit_lab (bus.commit_lab),
    .commit_res (bus.commit_res),
    .label_c    (bus.rf_label2),
    .val_c      (bus.rf_val2)
  );

  // State update: commit value/label-clear, then flush or issue (later assignment wins).
  always_ff @(posedge clk) begin
    if (!rst_in) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        val_q[i] <= '0;
        lab_q[i] <= LAB_NONE;
      end
    end else if (rdy_in) begin
      if (bus.commit_en && (bus.commit_rd != '0)) begin
        val_q[bus.commit_rd] <= bus.commit_res;
        if (lab_commit == bus.commit_lab) begin
          lab_q[bus.commit_rd] <= LAB_NONE;
        end
      end
      if (flush_in) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          lab_q[i] <= LAB_NONE;
        end
      end else if (bus.dec_en && (bus.dec_rd != '0)) begin
        lab_q[bus.dec_rd] <= bus.dec_tag;
      end
    end
  end

endmodule

// File: tb/tb_rename_reg_file.sv
// Directed bench for rename_reg_file.
module tb_rename_reg_file;
  import rename_reg_file_pkg::*;

  logic clk;
  logic rst_in;
  logic rdy_in;
  logic flush_in;
  int   errors;
  int   checks;

  rename_reg_file_if bus ();

  rename_reg_file dut (
    .clk      (clk),
    .rst_in   (rst_in),
    .rdy_in   (rdy_in),
    .flush_in (flush_in),
    .bus      (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // An issuing instruction must always carry a real ROB tag.
  always @(posedge clk) begin
    if (rst_in && rdy_in && !flush_in && bus.dec_en)
      assert (bus.dec_tag != LAB_NONE) else $error("dec_tag zero on issue");
  end

  task automatic idle();
    bus.dec_en     = 1'b0;
    bus.dec_rd     = '0;
    bus.dec_tag    = '0;
    bus.commit_en  = 1'b0;
    bus.commit_rd  = '0;
    bus.commit_res = '0;
    bus.commit_lab = '0;
    flush_in       = 1'b0;
  endtask

  // Advance one clock, leaving the bench 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int rd, input int tag);
    idle();
    bus.dec_en  = 1'b1;
    bus.dec_rd  = REG_WIDTH'(rd);
    bus.dec_tag = LAB_WIDTH'(tag);
    tick();
    idle();
  endtask

  task automatic test_reset();
    rst_in = 1'b0;
    rdy_in = 1'b1;
    idle();
    bus.dec_rs1 = 5'd5;
    bus.dec_rs2 = 5'd0;
    tick();
    tick();
    rst_in = 1'b1;
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL reset_lab_x5 got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'd0) begin errors++; $display("FAIL reset_val_x5 got=%0h exp=0", bus.rf_val1); end
    checks++; if (bus.rf_label2 !== 5'd0) begin errors++; $display("FAIL reset_lab_x0 got=%0d exp=0", bus.rf_label2); end
    checks++; if (bus.rf_val2 !== 32'd0) begin errors++; $display("FAIL reset_val_x0 got=%0h exp=0", bus.rf_val2); end
  endtask

  task automatic test_rename_commit();
    issue(3, 4);
    bus.dec_rs1 = 5'd3;
    #1;
    checks++; if (bus.rf_label1 !== 5'd4) begin errors++; $display("FAIL rename_lab got=%0d exp=4", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'd0) begin errors++; $display("FAIL rename_val got=%0h exp=0", bus.rf_val1); end
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd3;
    bus.commit_lab = 5'd4;
    bus.commit_res = 32'hDEAD;
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL bypass_lab got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'hDEAD) begin errors++; $display("FAIL bypass_val got=%0h exp=dead", bus.rf_val1); end
    tick();
    idle();
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL commit_lab got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'hDEAD) begin errors++; $display("FAIL commit_val got=%0h exp=dead", bus.rf_val1); end
  endtask

  task automatic test_overlap();
    issue(7, 2);
    issue(7, 5);
    bus.dec_rs1    = 5'd7;
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd7;
    bus.commit_lab = 5'd2;
    bus.commit_res = 32'd11;
    #1;
    checks++; if (bus.rf_label1 !== 5'd5) begin errors++; $display("FAIL stale_read_lab got=%0d exp=5", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'd0) begin errors++; $display("FAIL stale_read_val got=%0h exp=0", bus.rf_val1); end
    tick();
    idle();
    #1;
    checks++; if (bus.rf_label1 !== 5'd5) begin errors++; $display("FAIL stale_lab_kept got=%0d exp=5", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'd11) begin errors++; $display("FAIL stale_val got=%0d exp=11", bus.rf_val1); end
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd7;
    bus.commit_lab = 5'd5;
    bus.commit_res = 32'd22;
    tick();
    idle();
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL newest_lab got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'd22) begin errors++; $display("FAIL newest_val got=%0d exp=22", bus.rf_val1); end
  endtask

  task automatic test_conflict();
    issue(9, 3);
    bus.dec_rs1    = 5'd9;
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd9;
    bus.commit_lab = 5'd3;
    bus.commit_res = 32'h1234;
    bus.dec_en     = 1'b1;
    bus.dec_rd     = 5'd9;
    bus.dec_tag    = 5'd8;
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL conflict_read_lab got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'h1234) begin errors++; $display("FAIL conflict_read_val got=%0h exp=1234", bus.rf_val1); end
    tick();
    idle();
    #1;
    checks++; if (bus.rf_label1 !== 5'd8) begin errors++; $display("FAIL conflict_lab got=%0d exp=8", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'h1234) begin errors++; $display("FAIL conflict_val got=%0h exp=1234", bus.rf_val1); end
  endtask

  task automatic test_flush();
    issue(1, 1);
    issue(2, 2);
    issue(4, 3);
    bus.dec_rs1 = 5'd1;
    bus.dec_rs2 = 5'd4;
    #1;
    checks++; if (bus.rf_label1 !== 5'd1) begin errors++; $display("FAIL pre_flush_x1 got=%0d exp=1", bus.rf_label1); end
    checks++; if (bus.rf_label2 !== 5'd3) begin errors++; $display("FAIL pre_flush_x4 got=%0d exp=3", bus.rf_label2); end
    flush_in       = 1'b1;
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd1;
    bus.commit_lab = 5'd1;
    bus.commit_res = 32'd7;
    bus.dec_en     = 1'b1;
    bus.dec_rd     = 5'd6;
    bus.dec_tag    = 5'd9;
    bus.dec_rs1    = 5'd2;
    bus.dec_rs2    = 5'd1;
    #1;
    checks++; if (bus.rf_label1 !== 5'd2) begin errors++; $display("FAIL flush_cycle_x2 got=%0d exp=2", bus.rf_label1); end
    checks++; if (bus.rf_val2 !== 32'd7) begin errors++; $display("FAIL flush_cycle_bypass got=%0d exp=7", bus.rf_val2); end
    tick();
    idle();
    #1;
    checks++; if (bus.rf_label2 !== 5'd0) begin errors++; $display("FAIL flush_x1_lab got=%0d exp=0", bus.rf_label2); end
    checks++; if (bus.rf_val2 !== 32'd7) begin errors++; $display("FAIL flush_x1_val got=%0d exp=7", bus.rf_val2); end
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL flush_x2_lab got=%0d exp=0", bus.rf_label1); end
    bus.dec_rs1 = 5'd4;
    bus.dec_rs2 = 5'd6;
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL flush_x4_lab got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_label2 !== 5'd0) begin errors++; $display("FAIL flush_x6_lab got=%0d exp=0", bus.rf_label2); end
  endtask

  task automatic test_x0_stall();
    bus.dec_en     = 1'b1;
    bus.dec_rd     = 5'd0;
    bus.dec_tag    = 5'd5;
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd0;
    bus.commit_lab = 5'd0;
    bus.commit_res = 32'hFFFF;
    bus.dec_rs1    = 5'd0;
    #1;
    checks++; if (bus.rf_val1 !== 32'd0) begin errors++; $display("FAIL x0_same_cycle_val got=%0h exp=0", bus.rf_val1); end
    tick();
    idle();
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL x0_lab got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'd0) begin errors++; $display("FAIL x0_val got=%0h exp=0", bus.rf_val1); end
    rdy_in         = 1'b0;
    bus.dec_en     = 1'b1;
    bus.dec_rd     = 5'd10;
    bus.dec_tag    = 5'd6;
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd3;
    bus.commit_lab = 5'd0;
    bus.commit_res = 32'hBEEF;
    bus.dec_rs2    = 5'd3;
    #1;
    checks++; if (bus.rf_val2 !== 32'hBEEF) begin errors++; $display("FAIL stall_bypass_val got=%0h exp=beef", bus.rf_val2); end
    tick();
    tick();
    rdy_in = 1'b1;
    idle();
    bus.dec_rs1 = 5'd10;
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL stall_issue_lab got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_val2 !== 32'hDEAD) begin errors++; $display("FAIL stall_commit_val got=%0h exp=dead", bus.rf_val2); end
  endtask

  task automatic test_tag_wrap();
    issue(11, 16);
    bus.dec_rs1 = 5'd11;
    #1;
    checks++; if (bus.rf_label1 !== 5'd16) begin errors++; $display("FAIL max_tag_lab got=%0d exp=16", bus.rf_label1); end
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd11;
    bus.commit_lab = 5'd16;
    bus.commit_res = 32'd5;
    tick();
    idle();
    issue(11, 1);
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd11;
    bus.commit_lab = 5'd16;
    bus.commit_res = 32'd6;
    tick();
    idle();
    #1;
    checks++; if (bus.rf_label1 !== 5'd1) begin errors++; $display("FAIL wrap_lab got=%0d exp=1", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'd6) begin errors++; $display("FAIL wrap_val got=%0d exp=6", bus.rf_val1); end
  endtask

  task automatic test_midstream_reset();
    issue(14, 10);
    rst_in         = 1'b0;
    rdy_in         = 1'b0;
    bus.dec_en     = 1'b1;
    bus.dec_rd     = 5'd15;
    bus.dec_tag    = 5'd11;
    bus.commit_en  = 1'b1;
    bus.commit_rd  = 5'd14;
    bus.commit_lab = 5'd10;
    bus.commit_res = 32'd9;
    tick();
    rst_in = 1'b1;
    rdy_in = 1'b1;
    idle();
    bus.dec_rs1 = 5'd14;
    bus.dec_rs2 = 5'd15;
    #1;
    checks++; if (bus.rf_label1 !== 5'd0) begin errors++; $display("FAIL mid_reset_x14_lab got=%0d exp=0", bus.rf_label1); end
    checks++; if (bus.rf_val1 !== 32'd0) begin errors++; $display("FAIL mid_reset_x14_val got=%0d exp=0", bus.rf_val1); end
    checks++; if (bus.rf_label2 !== 5'd0) begin errors++; $display("FAIL mid_reset_x15_lab got=%0d exp=0", bus.rf_label2); end
    bus.dec_rs1 = 5'd3;
    #1;
    checks++; if (bus.rf_val1 !== 32'd0) begin errors++; $display("FAIL mid_reset_x3_val got=%0h exp=0", bus.rf_val1); end
  endtask

  initial begin
    errors      = 0;
    checks      = 0;
    rst_in      = 1'b0;
    rdy_in      = 1'b1;
    flush_in    = 1'b0;
    bus.dec_rs1 = '0;
    bus.dec_rs2 = '0;
    idle();
    test_reset();
    test_rename_commit();
    test_overlap();
    test_conflict();
    test_flush();
    test_x0_stall();
    test_tag_wrap();
    test_midstream_reset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rename_reg_file.md
Name: rename_reg_file

Overview:
- Architectural register file with per-register rename labels. It sits between the decoder/issue logic and the reorder buffer (ROB).
- Supplies the `rf_label*` / `rf_val*` operands the ROB uses to resolve source readiness.
- Records the ROB tag of the newest in-flight writer of each register.
- Absorbs ROB commit writes; clears all labels on ROB flush.

Parameters:
- NUM_REGS, 32, architectural register count (x0 hardwired zero)
- REG_WIDTH, 5, register index width
- VAL_WIDTH, 32, data width
- ROB_ID_WIDTH, 4, ROB index width; labels are ROB_ID_WIDTH+1 bits, 0 = no pending writer, valid tags 1..ROB_SIZE
- ROB_SIZE, 16, ROB entries (2**ROB_ID_WIDTH)

Ports:
- clk  in  1  clock
- rst_in  in  1  reset, synchronous, active-low
- rdy_in  in  1  global stall-release; state updates only when high
- flush_in  in  1  ROB mispredict flush
- dec_en  in  1  issue of an instruction this cycle
- dec_rd  in  REG_WIDTH  destination of issuing instruction
- dec_tag  in  ROB_ID_WIDTH+1  ROB tag allocated to issuing instruction
- dec_rs1  in  REG_WIDTH  source 1 index
- dec_rs2  in  REG_WIDTH  source 2 index
- commit_en  in  1  ROB commit of a register-writing instruction
- commit_rd  in  REG_WIDTH  committed destination
- commit_res  in  VAL_WIDTH  committed value
- commit_lab  in  ROB_ID_WIDTH+1  ROB tag of committed instruction
- rf_label1  out  ROB_ID_WIDTH+1  pending tag for rs1, 0 if none
- rf_val1  out  VAL_WIDTH  committed value of rs1
- rf_label2  out  ROB_ID_WIDTH+1  pending tag for rs2
- rf_val2  out  VAL_WIDTH  committed value of rs2

Behaviour:
- Storage: val[NUM_REGS], lab[NUM_REGS]. Index 0 is never written: val[0]=0, lab[0]=0 always.
- Reset (rst_in==0 at posedge): all val and lab set to 0. Reset overrides rdy_in, flush and all writes. Reset mid-stream discards all pending labels.
- Stall (rdy_in==0): no state change. Read outputs stay combinational on current state.

Read ports (combinational, zero latency, per port, rs = dec_rs1 or dec_rs2):
- rs==0 → label 0, value 0.
- Commit bypass: commit_en && commit_rd==rs && lab[rs]==commit_lab → label 0, value commit_res. This is required because the ROB clears the entry's ready bit on commit.
- Otherwise → label lab[rs], value val[rs]. The label takes the bypass-adjusted value even if flush_in is high.
- Reads never see the same-cycle rename by dec_en. An instruction reading its own rd gets the previous writer's tag/value.

Writes (posedge, rdy_in==1, rst_in==1):
- Commit: if commit_en && commit_rd!=0, val[commit_rd] <= commit_res. If also lab[commit_rd]==commit_lab, lab[commit_rd] <= 0, unless overridden by issue below. A stale tag mismatch updates the value only, label kept.
- Issue: if dec_en && dec_rd!=0 && !flush_in, lab[dec_rd] <= dec_tag. Issue wins over commit label-clear on the same register in the same cycle.
- Flush: if flush_in, every lab <= 0. A same-cycle commit value write is still performed, since the committed instruction is older than the flush point. Same-cycle dec_en is ignored.
- dec_tag==0 is illegal input; behaviour is unspecified, and the bench asserts it never occurs.
- Tag wrap: tags run 1..ROB_SIZE then back to 1. Matching is pure equality, no age compare.

Decomposition:
- Shared package/header (util.v style): REG_WIDTH, VAL_WIDTH, ROB_ID_WIDTH, ROB_SIZE macros and the label-zero "no writer" constant.
- One natural sub-module: rf_read_port, the combinational x0/bypass/lookup mux, instantiated twice.
- Top holds the arrays and the write logic.

Test Plan:
- Reset: rst_in=0 one cycle → all reads return label 0, value 0. Read x5 → (0, 0).
- Rename/commit: issue rd=x3 tag=4; next cycle read x3 → label 4. Commit rd=x3 lab=4 res=0xDEAD → same-cycle read gives (0, 0xDEAD); next cycle lab 0, val 0xDEAD.
- Overlapping writers: issue x7 tag=2, then x7 tag=5. Commit x7 lab=2 res=11 → val 11, label stays 5. Commit lab=5 res=22 → label 0, val 22.
- Same-cycle conflict: commit x9 lab=3 while issuing x9 tag=8 and reading rs1=x9 → read shows (0, commit_res). After edge, label 8 and val = commit_res.
- Flush: pending labels on x1, x2, x4; flush_in with commit x1 lab matching res=7 and dec_en x6 tag=9 → all labels 0, val[1]=7, x6 label 0.
- x0/stall: issue and commit targeting x0 → read x0 stays (0, 0). With rdy_in=0, an issue to x10 tag=6 is ignored → label stays 0.
